io_port_bank: RTL
=================

Name: io_port_bank

Overview:
- Parametrised memory-mapped I/O controller on the CPU/memory bus.
- Successor to the fixed 16-in/16-out, 8-bit port scheme: width and port count are generic.
- Adds a 2-flop input synchroniser and sticky per-port change flags.
- Adds write-1-to-clear status registers, per-port interrupt enables and an interrupt output.
- The top level muxes data_out into the CPU read path when hit=1.

Parameters:
- DATA_W, 8: bus and port data width.
- ADDR_W, 8: bus address width.
- N_PORTS, 16: number of input ports and output ports (1..2*DATA_W).
- OUT_BASE, 8'hE0: address of output port 0.
- IN_BASE, 8'hF0: address of input port 0.
- STAT_BASE, 8'hDC: first status register address; NS = ceil(N_PORTS/DATA_W) status registers, then NS enable registers.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  CPU bus address.
- data_in  in  DATA_W  CPU write data.
- write  in  1  write strobe, sampled on the clk rising edge.
- data_out  out  DATA_W  registered read data.
- hit  out  1  registered; address of the previous cycle decoded to this block.
- port_in  in  N_PORTS*DATA_W  flattened asynchronous inputs; port i = bits [i*DATA_W +: DATA_W].
- port_out  out  N_PORTS*DATA_W  flattened registered outputs.
- irq  out  1  level interrupt, registered.

Behaviour:
- Clocking: one clock, clk. reset is asynchronous and active-low.
- Reset (reset=0, any time, including mid-transfer): everything clears immediately.
  - port_out, data_out, hit, irq = 0.
  - sync stages, prev stage, chg flags, ien = 0.
  - Change detection restarts from zero on release, so a nonzero port_in flags once after reset.
- Address map (k = 0..N_PORTS-1, j = 0..NS-1):
  - OUT_BASE+k: output register k, read/write.
  - IN_BASE+k: synchronised input k, read-only; writes ignored.
  - STAT_BASE+j: chg[j*DATA_W +: DATA_W]; read, or write 1 to clear.
  - STAT_BASE+NS+j: ien slice j, read/write.
  - Any other address: hit=0, data_out=0, writes ignored.
  - Status bits beyond N_PORTS read 0.
- Output write: with write=1 and address=OUT_BASE+k, port_out[k]=data_in after that edge (visible 1 cycle later).
- Read: data_out and hit register the decode of the current address every cycle. This gives 1-cycle latency, matching the memory's synchronous read.
  - Reads have no side effects.
  - On a read concurrent with a write to the same register, data_out returns the old value.
- Input path, per port:
  - s1 <= port_in; s2 <= s1; prev <= s2.
  - Readable value is s2, 2 cycles after a port_in change.
  - When s2 != prev, chg[i] sets on that edge.
- Status clear: writing STAT_BASE+j with bit b=1 clears chg[j*DATA_W+b]. Bits written 0 are unchanged.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- irq <= |(chg & ien), one cycle after the flag or enable changes.
  - irq deasserts the cycle after the last enabled flag is cleared.
- Parameter checks: elaboration error if the map regions overlap, if N_PORTS > 2*DATA_W, or if a region exceeds 2^ADDR_W.

Decomposition:
- Package io_pkg:
  - Default address constants OUT_BASE, IN_BASE, STAT_BASE.
  - ceil_div function for NS.
  - Region-overlap check function.
- Sub-module io_sync_edge, instantiated N_PORTS times by generate:
  - Parameter DATA_W.
  - Ports clk, reset, d, q (= s2), changed (s2 != prev).
- Top io_port_bank contains the address decode, the output/ien/chg registers, the read mux and irq.

Test Plan:
1. Release reset, port_in=0, no writes -> all port_out=0, irq=0, data_out=0; reading 0xDC returns 0x00.
2. Write 0x5A to 0xE3 -> port_out[3]=0x5A the next cycle, others unchanged. Reading 0xE3 returns 0x5A one cycle after the address. Writing 0xF3 changes nothing.
3. port_in[9] 0x00->0x81 -> reading 0xF9 gives 0x81 from cycle 2 after the change; chg[9] set, so 0xDD reads 0x02.
4. Write 0x02 to 0xDF (ien[9]) with chg[9]=1 -> irq=1 next cycle. Write 0x02 to 0xDD -> chg[9]=0, irq=0 the cycle after.
5. Toggle port_in[9] so that s2 != prev on the same edge as a 0x02 write to 0xDD -> chg[9] stays 1 (set wins).
6. Assert reset mid-write with port_out[3]=0x5A and irq=1 -> port_out, irq, chg clear immediately, without waiting for clk. After release, registers stay 0 until written.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: default address map and elaboration-time helpers for io_port_bank.
package io_pkg;
  localparam int unsigned OUT_BASE = 'hE0;
  localparam int unsigned IN_BASE = 'hF0;
  localparam int unsigned STAT_BASE = 'hDC;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
  function automatic bit overlaps(input int a, input int a_len, input int b, input int b_len);
    return (a < b + b_len) && (b < a + a_len);
  endfunction
endpackage

// File: rtl/io_sync_edge.sv
// io_sync_edge: two-flop input synchroniser plus a previous-value stage for change detection.
module io_sync_edge #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              changed
);
  logic [DATA_W-1:0] s1, s2, prev;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      prev <= s2;
    end
  assign q = s2;
  assign changed = s2 != prev;
endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped I/O ports with synchronised inputs, sticky change flags and irq.
module io_port_bank
  import io_pkg::*;
#(
  parameter int          DATA_W = 8,
  parameter int          ADDR_W = 8,
  parameter int          N_PORTS = 16,
  parameter int unsigned OUT_BASE = io_pkg::OUT_BASE,
  parameter int unsigned IN_BASE = io_pkg::IN_BASE,
  parameter int unsigned STAT_BASE = io_pkg::STAT_BASE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         address,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      write,
  output logic [DATA_W-1:0]         data_out,
  output logic                      hit,
  input  logic [N_PORTS*DATA_W-1:0] port_in,
  output logic [N_PORTS*DATA_W-1:0] port_out,
  output logic                      irq
);
  localparam int NS = ceil_div(N_PORTS, DATA_W);
  localparam int SW = NS * DATA_W;
  localparam logic [SW-1:0] VALID = SW'({N_PORTS{1'b1}});
  if (overlaps(int'(OUT_BASE), N_PORTS, int'(IN_BASE), N_PORTS) ||
      overlaps(int'(OUT_BASE), N_PORTS, int'(STAT_BASE), 2 * NS) ||
      overlaps(int'(IN_BASE), N_PORTS, int'(STAT_BASE), 2 * NS)) begin : g_overlap
    $error("io_port_bank: address regions overlap");
  end
  if (N_PORTS < 1 || N_PORTS > 2 * DATA_W) begin : g_nports
    $error("io_port_bank: N_PORTS out of range");
  end
  if (int'(OUT_BASE) + N_PORTS > 2 ** ADDR_W || int'(IN_BASE) + N_PORTS > 2 ** ADDR_W ||
      int'(STAT_BASE) + 2 * NS > 2 ** ADDR_W) begin : g_range
    $error("io_port_bank: region exceeds address space");
  end
  logic [N_PORTS-1:0][DATA_W-1:0] out_r, out_nx, sync;
  logic [N_PORTS-1:0]             changed;
  logic [SW-1:0]                  chg, ien, ien_nx, clr, set_v;
  logic [DATA_W-1:0]              rd;
  logic                           rd_hit;
  for (genvar i = 0; i < N_PORTS; i++) begin : g_sync
    io_sync_edge #(.DATA_W(DATA_W)) u_sync (
      .clk(clk),
      .reset(reset),
      .d(port_in[i*DATA_W +: DATA_W]),
      .q(sync[i]),
      .changed(changed[i])
    );
  end
  assign set_v = SW'(changed);
  assign port_out = out_r;
  // Read mux always reflects pre-edge state, so a same-cycle write returns the old value.
  always_comb begin
    rd = '0;
    rd_hit = 1'b0;
    out_nx = out_r;
    ien_nx = ien;
    clr = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (address == ADDR_W'(OUT_BASE + k)) begin
        rd = out_r[k];
        rd_hit = 1'b1;
        out_nx[k] = write ? data_in : out_r[k];
      end
      if (address == ADDR_W'(IN_BASE + k)) begin
        rd = sync[k];
        rd_hit = 1'b1;
      end
    end
    for (int j = 0; j < NS; j++) begin
      if (address == ADDR_W'(STAT_BASE + j)) begin
        rd = chg[j*DATA_W +: DATA_W];
        rd_hit = 1'b1;
        clr[j*DATA_W +: DATA_W] = write ? data_in : '0;
      end
      if (address == ADDR_W'(STAT_BASE + NS + j)) begin
        rd = ien[j*DATA_W +: DATA_W];
        rd_hit = 1'b1;
        ien_nx[j*DATA_W +: DATA_W] = write ? data_in & VALID[j*DATA_W +: DATA_W] : ien[j*DATA_W +: DATA_W];
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_r <= '0;
      chg <= '0;
      ien <= '0;
      data_out <= '0;
      hit <= 1'b0;
      irq <= 1'b0;
    end else begin
      out_r <= out_nx;
      ien <= ien_nx;
      chg <= (chg & ~clr) | set_v;
      data_out <= rd;
      hit <= rd_hit;
      irq <= |(chg & ien);
    end
endmodule
